// File: rtl/wide_inv_sched.sv
// Round-robin scheduler that time-shares one registered-inverter datapath
// among NREQ requesters and returns each result tagged with its requester ID.
module wide_inv_sched #(
  parameter int WIDTH  = 32,
  parameter int NREQ   = 4,
  parameter int DP_LAT = 1
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      dp_d_in,
  input  logic [WIDTH-1:0]      dp_d_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2:0]            rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic [15:0]           done_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dp_d_in_q, dp_d_in_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [2:0]       rsp_id_q, rsp_id_d;
  logic [15:0]      done_count_q, done_count_d;

  logic             grant_found;
  logic [2:0]       grant_idx;
  logic [WIDTH-1:0] grant_data;
  int               best_off;
  int               off;

  // The valid requester with the smallest upward distance from ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    best_off    = NREQ;
    off         = 0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i >= int'(ptr_q)) ? (i - int'(ptr_q)) : (i + NREQ - int'(ptr_q));
      if (req_valid[i] && (off < best_off)) begin
        best_off    = off;
        grant_found = 1'b1;
        grant_idx   = 3'(i);
        grant_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst && (state_q == IDLE) && grant_found && (grant_idx == 3'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    dp_d_in_d    = dp_d_in_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    done_count_d = done_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          dp_d_in_d = grant_data;
          rsp_id_d  = grant_idx;
          ptr_d     = (int'(grant_idx) == NREQ - 1) ? 3'd0 : grant_idx + 3'd1;
          cnt_d     = 4'(DP_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d = dp_d_out;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight transaction without producing a response.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      dp_d_in_q    <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      dp_d_in_q    <= dp_d_in_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      done_count_q <= done_count_d;
    end
  end

  assign dp_d_in    = dp_d_in_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = done_count_q;
  assign rsp_valid  = rst && (state_q == RESP);
  assign busy       = rst && (state_q != IDLE);

endmodule

// File: tb/tb_wide_inv_sched.sv
// Scoreboard bench for wide_inv_sched: a transaction-level model predicts grants,
// response timing and inverted data; a negedge monitor compares against the DUT.
module tb_wide_inv_sched;

  localparam int WIDTH  = 32;
  localparam int NREQ   = 4;
  localparam int DP_LAT = 1;

  logic                  clock = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [WIDTH-1:0]      dp_d_in;
  logic [WIDTH-1:0]      dp_d_out = '0;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  logic [15:0]           done_count;

  wide_inv_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .DP_LAT(DP_LAT)) dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .dp_d_in    (dp_d_in),
    .dp_d_out   (dp_d_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .done_count (done_count)
  );

  always #5 clock = ~clock;

  // Stand-in for the wide_inv_reg datapath: one register stage that inverts.
  always @(posedge clock) dp_d_out <= ~dp_d_in;

  typedef struct packed {
    logic [2:0]       id;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t            exp_q[$];
  rsp_t            exp_e;
  int              errors = 0;
  int              checks = 0;
  int              cyc = 0;
  bit              m_busy = 1'b0;
  int              m_ptr = 0;
  int              m_age = 0;
  logic [15:0]     m_count = '0;
  bit              after_rst = 1'b0;
  bit              prev_hold = 1'b0;
  logic [2:0]      prev_id = '0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [NREQ-1:0] granted_vec = '0;
  logic [NREQ-1:0] exp_ready;
  bit              found;
  int              g_idx;
  int              grant_g;
  int              grant_cycles[$];
  int              grant_ids[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: model a single outstanding transaction and predict every output.
  always @(negedge clock) begin
    cyc++;
    granted_vec = '0;
    found = 1'b0;
    if (!rst) begin
      checkOutput("req_ready_in_reset", 64'(req_ready), 64'd0);
      checkOutput("busy_in_reset", 64'(busy), 64'd0);
      checkOutput("rsp_valid_in_reset", 64'(rsp_valid), 64'd0);
      m_busy = 1'b0; m_ptr = 0; m_age = 0; m_count = '0;
      exp_q.delete();
      prev_hold = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        checkOutput("reset_dp_d_in", 64'(dp_d_in), 64'd0);
        checkOutput("reset_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("reset_rsp_id", 64'(rsp_id), 64'd0);
        checkOutput("reset_done_count", 64'(done_count), 64'd0);
        after_rst = 1'b0;
      end
      if (m_busy) m_age++;
      exp_ready = '0;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          g_idx = (m_ptr + k) % NREQ;
          if (!found && req_valid[g_idx]) begin
            found = 1'b1;
            grant_g = g_idx;
            exp_ready[g_idx] = 1'b1;
          end
        end
      end
      checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
      checkOutput("busy", 64'(busy), 64'(m_busy));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_busy && (m_age >= DP_LAT + 2)));
      checkOutput("done_count", 64'(done_count), 64'(m_count));
      if (prev_hold) begin
        checkOutput("rsp_id_stable", 64'(rsp_id), 64'(prev_id));
        checkOutput("rsp_data_stable", 64'(rsp_data), 64'(prev_data));
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_id   = rsp_id;
      prev_data = rsp_data;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rsp_unexpected: got response id=%0d data=0x%0h, expected none", rsp_id, rsp_data);
        end else begin
          exp_e = exp_q.pop_front();
          checkOutput("rsp_id", 64'(rsp_id), 64'(exp_e.id));
          checkOutput("rsp_data", 64'(rsp_data), 64'(exp_e.data));
        end
        m_busy = 1'b0;
        m_count++;
      end
      if (found) begin
        exp_e.id   = 3'(grant_g);
        exp_e.data = ~req_data[grant_g*WIDTH +: WIDTH];
        exp_q.push_back(exp_e);
        m_busy = 1'b1;
        m_age  = 0;
        m_ptr  = (grant_g + 1) % NREQ;
        granted_vec = exp_ready;
        grant_cycles.push_back(cyc);
        grant_ids.push_back(grant_g);
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic sample();
    @(negedge clock); #1;
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] d, input logic rr);
    req_valid = v;
    req_data  = d;
    rsp_ready = rr;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    checkOutput("wait_idle", 64'(m_busy || exp_q.size() != 0), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation still running, required to finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    rst = 1'b0;
    applyStimulus('1, {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111}, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    sample();
    checkOutput("first_idle_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    waitIdle(20);

    // Single request from requester 2
    resetDut();
    applyStimulus(4'b0100, {32'h0, 32'h0000FFFF, 32'h0, 32'h0}, 1'b1);
    sample();
    checkOutput("single_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    n = 1;
    sample();
    while (!rsp_valid && n < 10) begin
      tick();
      sample();
      n++;
    end
    checkOutput("single_latency", 64'(n), 64'(DP_LAT + 2));
    checkOutput("single_rsp_data", 64'(rsp_data), 64'hFFFF0000);
    checkOutput("single_rsp_id", 64'(rsp_id), 64'd2);
    tick();
    sample();
    checkOutput("single_done_count", 64'(done_count), 64'd1);
    tick();

    // Round-robin with all four requesters held valid
    resetDut();
    grant_ids.delete();
    grant_cycles.delete();
    applyStimulus('1, {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111}, 1'b1);
    n = 0;
    while (grant_ids.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    checkOutput("rr_grant_count", 64'(grant_ids.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_ids.size()) begin
        checkOutput("rr_order", 64'(grant_ids[k]), 64'(k % NREQ));
        if (k > 0) checkOutput("rr_spacing", 64'(grant_cycles[k] - grant_cycles[k-1]), 64'(DP_LAT + 3));
      end
    end
    req_valid = '0;
    waitIdle(20);

    // Backpressure on the response port
    resetDut();
    applyStimulus(4'b1011, {32'h12345678, 32'h0, 32'hCAFEF00D, 32'h55555555}, 1'b0);
    sample();
    checkOutput("bp_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    sample();
    while (!rsp_valid && n < 10) begin
      tick();
      sample();
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_rsp_data", 64'(rsp_data), 64'hAAAAAAAA);
      checkOutput("bp_req_ready", 64'(req_ready), 64'd0);
      tick();
      sample();
    end
    tick();
    rsp_ready = 1'b1;
    sample();
    checkOutput("bp_not_done_yet", 64'(done_count), 64'd0);
    tick();
    sample();
    checkOutput("bp_done", 64'(done_count), 64'd1);
    checkOutput("bp_released", 64'(rsp_valid), 64'd0);
    checkOutput("bp_next_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    waitIdle(20);

    // Reset one cycle after a grant
    resetDut();
    applyStimulus(4'b0100, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}, 1'b1);
    sample();
    checkOutput("mw_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    sample();
    checkOutput("mw_busy", 64'(busy), 64'd0);
    checkOutput("mw_dp_d_in", 64'(dp_d_in), 64'd0);
    checkOutput("mw_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    req_valid = '1;
    sample();
    checkOutput("mw_ptr_restart", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    waitIdle(20);

    // Randomized traffic with occasional resets and response backpressure
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (granted_vec[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_data[i*WIDTH +: WIDTH] = $urandom();
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    waitIdle(40);

    // done_count wrap: preload near the top, then complete three transactions
    sample();
    force dut.done_count_q = 16'hFFFD;
    m_count = 16'hFFFD;
    #1;
    release dut.done_count_q;
    tick();
    for (int t = 0; t < 3; t++) begin
      req_valid = 4'b0001;
      req_data[WIDTH-1:0] = $urandom();
      sample();
      tick();
      req_valid = '0;
      waitIdle(20);
      sample();
      checkOutput("wrap_count", 64'(done_count), 64'(16'(32'hFFFE + t)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wide_inv_sched.md
# wide_inv_sched

Round-robin scheduler sharing one `wide_inv_reg` registered-inverter datapath among `NREQ` requesters. It accepts one request at a time through per-requester valid/ready handshakes and drives the datapath's `d_in`. It waits a fixed pipeline latency, captures the datapath's `d_out`, and returns it with the requester ID through a valid/ready response port. It sits between the request sources and the `wide_inv_reg` instance in the top-level datapath.

## Interface
- `WIDTH`, 32, datapath word width.
- `NREQ`, 4, number of requesters (2..8).
- `DP_LAT`, 1, datapath register latency in cycles (1..15).
- `clock`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (`rst=0` resets on the next rising edge).
- `req_valid`  in  NREQ  per-requester request valid.
- `req_data`  in  NREQ*WIDTH  requester i data in bits `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  NREQ  one-hot grant/accept.
- `dp_d_in`  out  WIDTH  registered drive to the datapath `d_in`.
- `dp_d_out`  in  WIDTH  datapath `d_out`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  3  ID of the requester being answered.
- `rsp_data`  out  WIDTH  captured `dp_d_out`.
- `busy`  out  1  high whenever the state is not IDLE.
- `done_count`  out  16  count of completed responses; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Select g = first i with `req_valid[i]`, scanning from `ptr` upward modulo NREQ.
  - Drive `req_ready[g]=1` combinationally; all other `req_ready` bits are 0. With no valid request, all `req_ready` bits are 0.
  - On the grant edge: `dp_d_in<=req_data[g]`, `rsp_id<=g`, `ptr<=(g+1) mod NREQ`, `cnt<=DP_LAT`, state→WAIT.
- WAIT:
  - `cnt` decrements by 1 per edge while `cnt!=0`.
  - On the edge where `cnt==0`: `rsp_data<=dp_d_out`, state→RESP.
  - `dp_d_in` holds its value throughout.
- RESP:
  - `rsp_valid=1`; `rsp_id` and `rsp_data` stay stable until the handshake edge (`rsp_valid & rsp_ready`).
  - On the handshake edge: `done_count` increments, state→IDLE.
  - No grant is made in the handshake cycle; `req_ready` is nonzero only in IDLE.
- `req_ready` is never asserted outside IDLE. `req_valid` deasserting while not granted is legal; the request is simply not counted.
- Arithmetic: `ptr` wraps at NREQ. `done_count` is a 16-bit modular counter.
- Reset, including mid-WAIT or mid-RESP:
  - state=IDLE, `ptr`=0, `cnt`=0.
  - `dp_d_in`=0, `rsp_data`=0, `rsp_id`=0, `done_count`=0.
  - `rsp_valid`=0, `busy`=0, `req_ready`=0 during the reset cycle.
  - Any in-flight transaction is dropped with no response.

## Timing
- Grant edge E0 → `dp_d_in` new value from E0.
- The datapath registers it at E1. For DP_LAT=1, `rsp_data` is captured at E(DP_LAT+1).
- `rsp_valid` is high starting in the cycle after E(DP_LAT+1).
- Minimum request-to-response latency is DP_LAT+1 cycles. Minimum issue period is DP_LAT+3 cycles when `rsp_ready=1`.
- `req_ready` is combinational from `req_valid`, `ptr` and state; all other outputs are registered.

## Test plan
- Reset: hold `rst=0` for 2 cycles with all `req_valid=1` → all outputs are 0, `req_ready`=0; after release, `req_ready`=4'b0001 in the first IDLE cycle.
- Single request, DP_LAT=1: requester 2 sends 0x0000FFFF with `rsp_ready=1`.
  - `req_ready`=4'b0100 on the grant edge.
  - `rsp_valid` high 2 cycles later with `rsp_data`=0xFFFF0000 and `rsp_id`=2.
  - `done_count`=1 afterwards.
- Round-robin: all four requesters are held valid with data 0x11111111, 0x22222222, 0x44444444 and 0x88888888.
  - Grants occur in order 0,1,2,3,0.
  - Responses are 0xEEEEEEEE, 0xDDDDDDDD, 0xBBBBBBBB, 0x77777777.
  - Grants are spaced 4 cycles apart.
- Backpressure: `rsp_ready=0` for 5 cycles after a request with data 0x55555555 → `rsp_valid` stays high with `rsp_data`=0xAAAAAAAA stable and no `req_ready` to other valid requesters; completion happens one cycle after `rsp_ready` rises.
- Reset mid-WAIT: assert `rst=0` one cycle after a grant → the next cycle shows state IDLE, `busy`=0, `dp_d_in`=0 and no `rsp_valid`; `ptr` restarts at 0.
- Counter wrap: preload via 65536 completed transactions (or force) → `done_count` goes 0xFFFF→0x0000.
